cryp_wr_arb: RTL

Write-channel arbiter for the cryp engine. It shares one AXI write master port among three requesters: key store (`key`), decrypt result (`d`) and encrypt result (`e`). It runs exactly one burst at a time through address, data and response phases, steers write beats from the granted client, and routes the write response back. It sits beside the read-side arbiter, ahead of the memory interconnect, and uses the same AXI IDs per client.

---
 rtl/cryp_wr_arb_if.sv | 63 ++++++
 rtl/cryp_wr_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cryp_wr_arb_if.sv
// ---------------------------------------------------------------------------
// cryp_wr_arb_if
//
// Purpose: bundles the AXI write master port of the cryp write arbiter
// (address, data and response channels) into one interface.
//
// Signals:
//   axi_wid / axi_waddr / axi_wlen / axi_wsize / axi_wburst / axi_wvalid
//                  write address channel, driven by the arbiter
//   axi_wready     address ready, driven by the memory side
//   axi_wd_data / axi_wd_strb / axi_wd_last / axi_wd_valid
//                  write data channel, driven by the arbiter
//   axi_wd_ready   data ready, driven by the memory side
//   axi_wr_bid / axi_wr_bresp / axi_wr_bvalid
//                  write response channel, driven by the memory side
//   axi_wr_bready  response ready, driven by the arbiter
//
// Modports: master (arbiter side), slave (memory/interconnect side).
// ---------------------------------------------------------------------------
interface cryp_wr_arb_if #(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 512
) ();

  logic [C_AXI_ID_WIDTH-1:0]       axi_wid;
  logic [C_AXI_ADDR_WIDTH-1:0]     axi_waddr;
  logic [7:0]                      axi_wlen;
  logic [2:0]                      axi_wsize;
  logic [1:0]                      axi_wburst;
  logic                            axi_wvalid;
  logic                            axi_wready;

  logic [C_AXI_DATA_WIDTH-1:0]     axi_wd_data;
  logic [C_AXI_DATA_WIDTH/8-1:0]   axi_wd_strb;
  logic                            axi_wd_last;
  logic                            axi_wd_valid;
  logic                            axi_wd_ready;

  logic [C_AXI_ID_WIDTH-1:0]       axi_wr_bid;
  logic [1:0]                      axi_wr_bresp;
  logic                            axi_wr_bvalid;
  logic                            axi_wr_bready;

  modport master (
    output axi_wid, axi_waddr, axi_wlen, axi_wsize, axi_wburst, axi_wvalid,
    input  axi_wready,
    output axi_wd_data, axi_wd_strb, axi_wd_last, axi_wd_valid,
    input  axi_wd_ready,
    input  axi_wr_bid, axi_wr_bresp, axi_wr_bvalid,
    output axi_wr_bready
  );

  modport slave (
    input  axi_wid, axi_waddr, axi_wlen, axi_wsize, axi_wburst, axi_wvalid,
    output axi_wready,
    input  axi_wd_data, axi_wd_strb, axi_wd_last, axi_wd_valid,
    output axi_wd_ready,
    output axi_wr_bid, axi_wr_bresp, axi_wr_bvalid,
    input  axi_wr_bready
  );

endinterface

// File: rtl/cryp_wr_arb.sv
// ---------------------------------------------------------------------------
// cryp_wr_arb
//
// Purpose: write-channel arbiter for the cryp engine. Three requesters
// (key store "key", decrypt result "d", encrypt result "e") share one AXI
// write master port. Exactly one burst is in flight at a time; it walks
// through the address, data and response phases before the next grant.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   X_wr_req/addr/len     burst request (level), start address, beats-1
//   X_wr_grant            one-cycle pulse when the request is latched
//   X_wr_data/dvalid      write beat from the client
//   X_wr_dready           beat accepted this cycle (granted client only)
//   X_wr_done/resp        one-cycle pulse with the burst's BRESP
//   axi                   AXI write master (cryp_wr_arb_if.master)
//   wr_busy               FSM is not IDLE
//   (X is key, d, e)
//
// Configuration macro: CRYP_WR_RR_EN
//   defined   -> round-robin arbitration, search order key->d->e->key
//                starting after the last granted client
//   undefined -> fixed priority key > d > e
// ---------------------------------------------------------------------------
module cryp_wr_arb #(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 512
) (
  input  logic                          aclk,
  input  logic                          areset,

  input  logic                          key_wr_req,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   key_wr_addr,
  input  logic [7:0]                    key_wr_len,
  output logic                          key_wr_grant,
  input  logic [C_AXI_DATA_WIDTH-1:0]   key_wr_data,
  input  logic                          key_wr_dvalid,
  output logic                          key_wr_dready,
  output logic                          key_wr_done,
  output logic [1:0]                    key_wr_resp,

  input  logic                          d_wr_req,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   d_wr_addr,
  input  logic [7:0]                    d_wr_len,
  output logic                          d_wr_grant,
  input  logic [C_AXI_DATA_WIDTH-1:0]   d_wr_data,
  input  logic                          d_wr_dvalid,
  output logic                          d_wr_dready,
  output logic                          d_wr_done,
  output logic [1:0]                    d_wr_resp,

  input  logic                          e_wr_req,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   e_wr_addr,
  input  logic [7:0]                    e_wr_len,
  output logic                          e_wr_grant,
  input  logic [C_AXI_DATA_WIDTH-1:0]   e_wr_data,
  input  logic                          e_wr_dvalid,
  output logic                          e_wr_dready,
  output logic                          e_wr_done,
  output logic [1:0]                    e_wr_resp,

  cryp_wr_arb_if.master                 axi,

  output logic                          wr_busy
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int IW = C_AXI_ID_WIDTH;

  // Client indices used for every per-client vector below.
  localparam logic [1:0] CLI_KEY = 2'd0;
  localparam logic [1:0] CLI_D   = 2'd1;
  localparam logic [1:0] CLI_E   = 2'd2;

  localparam logic [2:0] WSIZE = 3'($clog2(DW / 8));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IW-1:0]     id_q, id_d;
  logic              wvalid_q, wvalid_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        done_q, done_d;
  logic [2:0][1:0]   resp_q, resp_d;

  logic [2:0]            req;
  logic [2:0][AW-1:0]    reqAddr;
  logic [2:0][7:0]       reqLen;
  logic [2:0][DW-1:0]    cliData;
  logic [2:0]            cliDvalid;

  logic              winValid;
  logic [1:0]        winIdx;
  logic [DW-1:0]     selData;
  logic              selDvalid;
  logic              inData;
  logic              beatHs;
  logic              lastBeat;
  logic              unusedBid;

  assign req       = {e_wr_req, d_wr_req, key_wr_req};
  assign reqAddr   = {e_wr_addr, d_wr_addr, key_wr_addr};
  assign reqLen    = {e_wr_len, d_wr_len, key_wr_len};
  assign cliData   = {e_wr_data, d_wr_data, key_wr_data};
  assign cliDvalid = {e_wr_dvalid, d_wr_dvalid, key_wr_dvalid};

  // Only one burst is ever outstanding, so BID carries no routing value.
  assign unusedBid = ^axi.axi_wr_bid;

  // Fixed AXI IDs per client, shared with the read-side arbiter.
  function automatic logic [IW-1:0] cliId(input logic [1:0] cli);
    case (cli)
      CLI_KEY: cliId = IW'(2);
      CLI_D:   cliId = IW'(0);
      default: cliId = IW'(1);
    endcase
  endfunction

`ifdef CRYP_WR_RR_EN
  logic [1:0] rrPtr_q;
  logic [1:0] cand0, cand1, cand2;

  // Round-robin winner: search starts at the client after the last grant.
  // The pointer resets to e so key is the first one looked at.
  always_comb begin
    cand0 = CLI_KEY;
    cand1 = CLI_D;
    cand2 = CLI_E;
    case (rrPtr_q)
      CLI_KEY: begin cand0 = CLI_D;  cand1 = CLI_E;   cand2 = CLI_KEY; end
      CLI_D:   begin cand0 = CLI_E;  cand1 = CLI_KEY; cand2 = CLI_D;   end
      default: ;
    endcase
    winValid = |req;
    winIdx   = cand2;
    if (req[cand0]) begin
      winIdx = cand0;
    end else if (req[cand1]) begin
      winIdx = cand1;
    end
  end

  // Pointer remembers the most recently granted client.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rrPtr_q <= CLI_E;
    end else if (state_q == IDLE && winValid) begin
      rrPtr_q <= winIdx;
    end
  end
`else
  // Fixed priority winner: key over d over e.
  always_comb begin
    winValid = |req;
    winIdx   = CLI_E;
    if (req[CLI_KEY]) begin
      winIdx = CLI_KEY;
    end else if (req[CLI_D]) begin
      winIdx = CLI_D;
    end
  end
`endif

  // Steer the granted client's beat onto the bus. Data is a pure mux so a
  // beat passes in the same cycle the client presents it.
  always_comb begin
    selData   = cliData[CLI_E];
    selDvalid = cliDvalid[CLI_E];
    case (sel_q)
      CLI_KEY: begin selData = cliData[CLI_KEY]; selDvalid = cliDvalid[CLI_KEY]; end
      CLI_D:   begin selData = cliData[CLI_D];   selDvalid = cliDvalid[CLI_D];   end
      default: ;
    endcase
  end

  assign inData   = (state_q == DATA);
  assign lastBeat = (cnt_q == len_q);
  assign beatHs   = inData && selDvalid && axi.axi_wd_ready;

  // Next-state logic: the burst walks IDLE -> ADDR -> DATA -> RESP -> IDLE.
  // Grant and done are single-cycle pulses, so they default to zero here.
  // The beat counter stops at len (the last beat leaves DATA instead of
  // incrementing), which keeps len=255 from wrapping.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    wvalid_d = wvalid_q;
    grant_d  = '0;
    done_d   = '0;
    resp_d   = resp_q;

    case (state_q)
      IDLE: begin
        if (winValid) begin
          sel_d           = winIdx;
          addr_d          = reqAddr[winIdx];
          len_d           = reqLen[winIdx];
          id_d            = cliId(winIdx);
          cnt_d           = 8'd0;
          grant_d[winIdx] = 1'b1;
          wvalid_d        = 1'b1;
          state_d         = ADDR;
        end
      end
      ADDR: begin
        if (wvalid_q && axi.axi_wready) begin
          wvalid_d = 1'b0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (beatHs) begin
          if (lastBeat) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      RESP: begin
        if (axi.axi_wr_bvalid) begin
          done_d[sel_q] = 1'b1;
          resp_d[sel_q] = axi.axi_wr_bresp;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched burst parameters. Reset abandons any burst in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      sel_q    <= CLI_KEY;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      wvalid_q <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      wvalid_q <= wvalid_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
    end
  end

  assign axi.axi_wid    = id_q;
  assign axi.axi_waddr  = addr_q;
  assign axi.axi_wlen   = len_q;
  assign axi.axi_wsize  = WSIZE;
  assign axi.axi_wburst = 2'b01;
  assign axi.axi_wvalid = wvalid_q;

  assign axi.axi_wd_data  = selData;
  assign axi.axi_wd_strb  = '1;
  assign axi.axi_wd_valid = inData && selDvalid;
  assign axi.axi_wd_last  = inData && lastBeat;

  assign axi.axi_wr_bready = (state_q == RESP);

  assign key_wr_dready = inData && (sel_q == CLI_KEY) && axi.axi_wd_ready;
  assign d_wr_dready   = inData && (sel_q == CLI_D)   && axi.axi_wd_ready;
  assign e_wr_dready   = inData && (sel_q == CLI_E)   && axi.axi_wd_ready;

  assign key_wr_grant = grant_q[CLI_KEY];
  assign d_wr_grant   = grant_q[CLI_D];
  assign e_wr_grant   = grant_q[CLI_E];

  assign key_wr_done = done_q[CLI_KEY];
  assign d_wr_done   = done_q[CLI_D];
  assign e_wr_done   = done_q[CLI_E];

  assign key_wr_resp = resp_q[CLI_KEY];
  assign d_wr_resp   = resp_q[CLI_D];
  assign e_wr_resp   = resp_q[CLI_E];

  assign wr_busy = (state_q != IDLE);

endmodule
